// File: rtl/qbus_master_arb.sv
// qbus_master_arb
//   Two-requester Q-bus master: round-robin arbitration between two internal
//   masters and sequencing of complete nAD/nSYNC/nDIN/nDOUT/nWTBT bus cycles.
//   Each cycle waits for nRPLY and is aborted after TIMEOUT reply-wait cycles.
//
// Ports
//   PIN_CLK, PIN_nDCLO         clock, asynchronous active-low reset
//   req_i/we_i/byte_i          per-requester request, write flag, byte flag
//   addr0_i/addr1_i            per-requester cycle address
//   wdata0_i/wdata1_i          per-requester write data
//   grant_o/ack_o/err_o        owner, completion pulse, timeout flag
//   rdata_o                    last read data (true polarity)
//   PIN_nAD_out/oe/in          inverted multiplexed address/data bus
//   PIN_nSYNC/nDIN/nDOUT/nWTBT bus strobes (active-low)
//   PIN_nRPLY                  slave reply (active-low)
//
// Every output is a register decoded from the current state, so pins change
// one clock after the state they reflect.
module qbus_master_arb #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        PIN_CLK,
    input  logic        PIN_nDCLO,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [1:0]  byte_i,
    input  logic [15:0] addr0_i,
    input  logic [15:0] addr1_i,
    input  logic [15:0] wdata0_i,
    input  logic [15:0] wdata1_i,
    output logic [1:0]  grant_o,
    output logic [1:0]  ack_o,
    output logic        err_o,
    output logic [15:0] rdata_o,
    output logic [15:0] PIN_nAD_out,
    output logic        PIN_nAD_oe,
    input  logic [15:0] PIN_nAD_in,
    output logic        PIN_nSYNC,
    output logic        PIN_nDIN,
    output logic        PIN_nDOUT,
    output logic        PIN_nWTBT,
    input  logic        PIN_nRPLY
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAdr,
        StSyn,
        StDat,
        StWrp,
        StFin
    } state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic            we_q, we_d;
    logic            byte_q, byte_d;
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            tmo_q, tmo_d;
    logic [15:0]     rdata_q, rdata_d;

    logic [1:0]      grant_q, grant_d;
    logic [1:0]      ack_q, ack_d;
    logic            err_q, err_d;
    logic [15:0]     nad_q, nad_d;
    logic            oe_q, oe_d;
    logic            nsync_q, nsync_d;
    logic            ndin_q, ndin_d;
    logic            ndout_q, ndout_d;
    logic            nwtbt_q, nwtbt_d;

    logic            win;
    logic [1:0]      own_oh;
    logic [CntW-1:0] cnt_inc;

    // On a tie the requester that did not own the last cycle wins.
    always_comb begin
        if (req_i == 2'b11) begin
            win = ~last_q;
        end else begin
            win = req_i[1];
        end
    end

    assign own_oh  = owner_q ? 2'b10 : 2'b01;
    // Saturate so a reply on the last WRP cycle cannot wrap the FIN budget.
    assign cnt_inc = (cnt_q == CntLast) ? cnt_q : cnt_q + CntW'(1);

    // Next state and latched operands.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                // done_q marks the cycle in which ack_o is being raised.
                if ((req_i != 2'b00) && !done_q) begin
                    owner_d = win;
                    last_d  = win;
                    we_d    = we_i[win];
                    byte_d  = byte_i[win];
                    addr_d  = win ? addr1_i : addr0_i;
                    wdata_d = win ? wdata1_i : wdata0_i;
                    state_d = StAdr;
                end
            end
            StAdr: state_d = StSyn;
            StSyn: begin
                cnt_d   = '0;
                state_d = we_q ? StDat : StWrp;
            end
            StDat: begin
                cnt_d   = '0;
                state_d = StWrp;
            end
            StWrp: begin
                if (!PIN_nRPLY) begin
                    state_d = StFin;
                    cnt_d   = cnt_inc;
                    if (!we_q) begin
                        rdata_d = ~PIN_nAD_in;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StFin: begin
                if (PIN_nRPLY) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    tmo_d   = 1'b0;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pin and status values for the next clock, decoded from the current state.
    always_comb begin
        grant_d = 2'b00;
        ack_d   = 2'b00;
        err_d   = 1'b0;
        nad_d   = 16'hFFFF;
        oe_d    = 1'b0;
        nsync_d = 1'b1;
        ndin_d  = 1'b1;
        ndout_d = 1'b1;
        nwtbt_d = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (done_q) begin
                    ack_d = own_oh;
                    err_d = tmo_q;
                end
            end
            StAdr, StSyn: begin
                grant_d = own_oh;
                oe_d    = 1'b1;
                nad_d   = ~addr_q;
                nwtbt_d = ~we_q;
                nsync_d = (state_q == StAdr);
            end
            StDat: begin
                grant_d = own_oh;
                oe_d    = 1'b1;
                nad_d   = ~wdata_q;
                nwtbt_d = ~byte_q;
                nsync_d = 1'b0;
            end
            StWrp, StFin: begin
                grant_d = own_oh;
                nsync_d = 1'b0;
                if (we_q) begin
                    // Write data stays on the bus until nSYNC rises.
                    oe_d    = 1'b1;
                    nad_d   = ~wdata_q;
                    nwtbt_d = ~byte_q;
                    ndout_d = (state_q == StFin);
                end else begin
                    ndin_d = (state_q == StFin);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge PIN_CLK or negedge PIN_nDCLO) begin
        if (!PIN_nDCLO) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            rdata_q <= '0;
            grant_q <= 2'b00;
            ack_q   <= 2'b00;
            err_q   <= 1'b0;
            nad_q   <= 16'hFFFF;
            oe_q    <= 1'b0;
            nsync_q <= 1'b1;
            ndin_q  <= 1'b1;
            ndout_q <= 1'b1;
            nwtbt_q <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            nad_q   <= nad_d;
            oe_q    <= oe_d;
            nsync_q <= nsync_d;
            ndin_q  <= ndin_d;
            ndout_q <= ndout_d;
            nwtbt_q <= nwtbt_d;
        end
    end

    assign grant_o     = grant_q;
    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign PIN_nAD_out = nad_q;
    assign PIN_nAD_oe  = oe_q;
    assign PIN_nSYNC   = nsync_q;
    assign PIN_nDIN    = ndin_q;
    assign PIN_nDOUT   = ndout_q;
    assign PIN_nWTBT   = nwtbt_q;

endmodule
